mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2:1 data mux and its output channel between two requesters.
- Drives the mux select, issues grants, and carries valid/ready handshake across the shared channel.
- Supports multi-beat packets via last flags; a hold limit forces rotation so neither side starves.
- Sits between two producer blocks and a single downstream consumer.

---
 rtl/mux_rr_arbiter_if.sv | 43 ++++
 rtl/mux_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the two producers, the round-robin arbiter and the consumer.
// Optional grant counters gcnt0/gcnt1 appear only when ARB_STATS_EN is defined.
interface mux_rr_arbiter_if #(
    parameter int DW = 8
);
    logic          req0;
    logic          req1;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic          last0;
    logic          last1;
    logic          gnt0;
    logic          gnt1;
    logic          sel;
    logic          rdy0;
    logic          rdy1;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
`ifdef ARB_STATS_EN
    logic [15:0]   gcnt0;
    logic [15:0]   gcnt1;
`endif

    // Arbiter side
    modport slave (
        input  req0, req1, din0, din1, last0, last1, out_ready,
        output gnt0, gnt1, sel, rdy0, rdy1, out_valid, out_data, out_last
`ifdef ARB_STATS_EN
        , output gcnt0, gcnt1
`endif
    );

    // Producer/consumer side
    modport master (
        output req0, req1, din0, din1, last0, last1, out_ready,
        input  gnt0, gnt1, sel, rdy0, rdy1, out_valid, out_data, out_last
`ifdef ARB_STATS_EN
        , input gcnt0, gcnt1
`endif
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-way round-robin arbiter driving a shared 2:1 data mux with packet-aware hold limit.
// Define ARB_STATS_EN to add 16-bit per-requester grant-entry counters.
module mux_rr_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_t        r_state;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_sel;
    logic          r_last_served;
    logic [7:0]    r_beats;
`ifdef ARB_STATS_EN
    logic [15:0]   r_gcnt0;
    logic [15:0]   r_gcnt1;
`endif

    logic          w_own_req;
    logic          w_oth_req;
    logic          w_own_last;
    logic          w_valid;
    logic          w_xfer;
    logic          w_at_limit;
    logic          w_rel;
    logic          w_pick0;
    logic [DW-1:0] w_data;

    assign w_own_req  = r_sel ? bus.req1  : bus.req0;
    assign w_oth_req  = r_sel ? bus.req0  : bus.req1;
    assign w_own_last = r_sel ? bus.last1 : bus.last0;
    assign w_data     = r_sel ? bus.din1  : bus.din0;

    // Handshake is suppressed while reset is asserted so no beat leaks in that cycle.
    assign w_valid    = rst_n & (r_gnt0 | r_gnt1) & w_own_req;
    assign w_xfer     = w_valid & bus.out_ready;
    assign w_at_limit = (r_beats == HOLD_LIM);
    assign w_rel      = (w_xfer & w_own_last)
                      | (w_xfer & w_at_limit & w_oth_req)
                      | (~w_own_req & ~w_xfer);
    assign w_pick0    = bus.req0 & (~bus.req1 | r_last_served);

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.sel       = r_sel;
    assign bus.rdy0      = rst_n & r_gnt0 & bus.out_ready;
    assign bus.rdy1      = rst_n & r_gnt1 & bus.out_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;
    assign bus.out_last  = (r_gnt0 & bus.last0) | (r_gnt1 & bus.last1);
`ifdef ARB_STATS_EN
    assign bus.gcnt0     = r_gcnt0;
    assign bus.gcnt1     = r_gcnt1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_sel         <= 1'b0;
            r_beats       <= '0;
            r_last_served <= 1'b1;
`ifdef ARB_STATS_EN
            r_gcnt0       <= '0;
            r_gcnt1       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_beats <= '0;
                    if (w_pick0) begin
                        r_state <= G0;
                        r_gnt0  <= 1'b1;
                        r_gnt1  <= 1'b0;
                        r_sel   <= 1'b0;
`ifdef ARB_STATS_EN
                        r_gcnt0 <= r_gcnt0 + 16'd1;
`endif
                    end else if (bus.req1) begin
                        r_state <= G1;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b1;
                        r_sel   <= 1'b1;
`ifdef ARB_STATS_EN
                        r_gcnt1 <= r_gcnt1 + 16'd1;
`endif
                    end
                end
                G0, G1: begin
                    if (w_xfer) begin
                        r_last_served <= r_sel;
                    end
                    // Release hands straight over to a waiting peer, otherwise falls back to IDLE.
                    if (w_rel) begin
                        r_beats <= '0;
                        if (w_oth_req) begin
                            r_state <= r_sel ? G0 : G1;
                            r_gnt0  <= r_sel;
                            r_gnt1  <= ~r_sel;
                            r_sel   <= ~r_sel;
`ifdef ARB_STATS_EN
                            if (r_sel) begin
                                r_gcnt0 <= r_gcnt0 + 16'd1;
                            end else begin
                                r_gcnt1 <= r_gcnt1 + 16'd1;
                            end
`endif
                        end else begin
                            r_state <= IDLE;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b0;
                            r_sel   <= 1'b0;
                        end
                    end else if (w_xfer && !w_at_limit) begin
                        r_beats <= r_beats + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_sel   <= 1'b0;
                    r_beats <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a transaction-level grant model predicts accepted beats.
module tb_mux_rr_arbiter;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;

    typedef struct {
        int            src;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.DW(DW)) bus();

    mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    beat_t sb[$];
    beat_t pq0[$];
    beat_t pq1[$];
    beat_t mon_b;

    int n_cmp = 0;
    int n_bad = 0;

    int m_own  = -1;
    int m_run  = 0;
    int m_prev = 1;
    int m_ent0 = 0;
    int m_ent1 = 0;
    logic e_gnt0 = 1'b0, e_gnt1 = 1'b0, e_valid = 1'b0, e_last = 1'b0;
    logic e_rdy0 = 1'b0, e_rdy1 = 1'b0;
    logic m_en = 1'b0;

    int   p_req = 100;
    int   p_rdy = 100;
    logic rst_req = 1'b1;
    logic hold0 = 1'b0, hold1 = 1'b0, acc0 = 1'b0, acc1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int src, input int len, input logic [DW-1:0] base, input bit rnd);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.src = src;
            b.d   = rnd ? DW'($urandom) : base + DW'(i);
            b.l   = (i == len - 1);
            if (src == 0) pq0.push_back(b);
            else          pq1.push_back(b);
        end
    endtask

    // Grant policy written as "who owns the channel and how many beats it has had".
    task automatic model_eval();
        logic          rq[2];
        logic          lst[2];
        logic [DW-1:0] dd[2];
        logic          xfer;
        int            x;
        int            o;
        rq[0] = bus.req0;  rq[1] = bus.req1;
        lst[0] = bus.last0; lst[1] = bus.last1;
        dd[0] = bus.din0;  dd[1] = bus.din1;
        e_gnt0 = (m_own == 0);
        e_gnt1 = (m_own == 1);
        e_last = (m_own >= 0) ? lst[m_own] : 1'b0;
        if (!rst_n) begin
            e_valid = 1'b0; e_rdy0 = 1'b0; e_rdy1 = 1'b0;
            m_own = -1; m_run = 0; m_prev = 1; m_ent0 = 0; m_ent1 = 0;
            return;
        end
        e_rdy0 = e_gnt0 && bus.out_ready;
        e_rdy1 = e_gnt1 && bus.out_ready;
        if (m_own < 0) begin
            e_valid = 1'b0;
            m_run   = 0;
            if (rq[0] || rq[1]) begin
                m_own = (rq[0] && rq[1]) ? 1 - m_prev : (rq[0] ? 0 : 1);
                if (m_own == 0) m_ent0++; else m_ent1++;
            end
        end else begin
            x = m_own;
            o = 1 - x;
            e_valid = rq[x];
            xfer = e_valid && bus.out_ready;
            if (xfer) begin
                sb.push_back('{x, dd[x], lst[x]});
                m_prev = x;
                m_run++;
            end
            if ((xfer && lst[x]) || (xfer && m_run >= MAX_HOLD && rq[o]) || !rq[x]) begin
                m_run = 0;
                if (rq[o]) begin
                    m_own = o;
                    if (o == 0) m_ent0++; else m_ent1++;
                end else begin
                    m_own = -1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (acc0) begin pq0.delete(0); hold0 = 1'b0; end
        if (acc1) begin pq1.delete(0); hold1 = 1'b0; end
        rst_n     = ~rst_req;
        bus.req0  = (pq0.size() > 0) && (hold0 || ($urandom_range(99) < p_req));
        bus.req1  = (pq1.size() > 0) && (hold1 || ($urandom_range(99) < p_req));
        if (bus.req0) hold0 = 1'b1;
        if (bus.req1) hold1 = 1'b1;
        bus.din0  = (pq0.size() > 0) ? pq0[0].d : '0;
        bus.last0 = (pq0.size() > 0) ? pq0[0].l : 1'b0;
        bus.din1  = (pq1.size() > 0) ? pq1[0].d : '0;
        bus.last1 = (pq1.size() > 0) ? pq1[0].l : 1'b0;
        bus.out_ready = ($urandom_range(99) < p_rdy);
        #2;
        model_eval();
        acc0 = bus.rdy0 && bus.out_valid;
        acc1 = bus.rdy1 && bus.out_valid;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pq0.size() + pq1.size()) > 0 && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        check("pending_beats", 32'(pq0.size() + pq1.size()), 32'd0);
        check("scoreboard_left", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (m_en) begin
            check("gnt", {30'd0, bus.gnt0, bus.gnt1}, {30'd0, e_gnt0, e_gnt1});
            check("sel", {31'd0, bus.sel}, {31'd0, e_gnt1});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, e_valid});
            check("out_last", {31'd0, bus.out_last}, {31'd0, e_last});
            check("rdy", {30'd0, bus.rdy0, bus.rdy1}, {30'd0, e_rdy0, e_rdy1});
            if (bus.out_valid && (bus.rdy0 || bus.rdy1)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat: got unexpected beat data %0h expected none at %0t", bus.out_data, $time);
                end else begin
                    mon_b = sb.pop_front();
                    check("beat_src", {31'd0, bus.rdy1}, 32'(mon_b.src));
                    check("beat_data", 32'(bus.out_data), 32'(mon_b.d));
                    check("beat_last", {31'd0, bus.out_last}, {31'd0, mon_b.l});
                end
            end
        end
    end

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.din0 = '0; bus.din1 = '0;
        bus.last0 = 1'b0; bus.last1 = 1'b0; bus.out_ready = 1'b0;

        rst_req = 1'b1;
        step();
        step();
        m_en = 1'b1;
        check("reset_gnt0", {31'd0, bus.gnt0}, 32'd0);
        check("reset_gnt1", {31'd0, bus.gnt1}, 32'd0);
        check("reset_sel", {31'd0, bus.sel}, 32'd0);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_out_last", {31'd0, bus.out_last}, 32'd0);
`ifdef ARB_STATS_EN
        check("reset_gcnt0", 32'(bus.gcnt0), 32'd0);
        check("reset_gcnt1", 32'(bus.gcnt1), 32'd0);
`endif
        rst_req = 1'b0;
        p_req = 100;
        p_rdy = 100;

        // Single beat on requester 0
        add_pkt(0, 1, 8'hA5, 1'b0);
        drain(50);

        // Tied single-beat packets alternate
        for (int i = 0; i < 4; i++) begin
            add_pkt(0, 1, 8'h10 + 8'(i), 1'b0);
            add_pkt(1, 1, 8'h20 + 8'(i), 1'b0);
        end
        drain(100);

        // Long packet against a constant contender forces rotation
        add_pkt(0, 10, 8'h40, 1'b0);
        add_pkt(1, 8, 8'h80, 1'b0);
        drain(200);

        // Uncontended 6-beat packet stays in one grant
        add_pkt(0, 6, 8'h60, 1'b0);
        drain(100);

        // Backpressure while granted to requester 1
        add_pkt(1, 2, 8'h3C, 1'b0);
        p_rdy = 0;
        for (int i = 0; i < 6; i++) step();
        check("bp_gnt1", {31'd0, bus.gnt1}, 32'd1);
        check("bp_rdy1", {31'd0, bus.rdy1}, 32'd0);
        p_rdy = 100;
        drain(100);

        // Reset in the middle of a requester-1 packet
        add_pkt(1, 8, 8'hC0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        rst_req = 1'b1;
        step();
        pq0.delete();
        pq1.delete();
        hold0 = 1'b0;
        hold1 = 1'b0;
        rst_req = 1'b0;
        step();
        check("midrst_gnt1", {31'd0, bus.gnt1}, 32'd0);
        check("midrst_sel", {31'd0, bus.sel}, 32'd0);
`ifdef ARB_STATS_EN
        check("midrst_gcnt0", 32'(bus.gcnt0), 32'd0);
        check("midrst_gcnt1", 32'(bus.gcnt1), 32'd0);
`endif
        add_pkt(0, 1, 8'hD0, 1'b0);
        add_pkt(1, 1, 8'hD1, 1'b0);
        drain(50);

        // Randomized traffic with gaps and backpressure
        p_req = 70;
        p_rdy = 70;
        for (int i = 0; i < 30; i++) begin
            add_pkt(int'($urandom_range(1)), int'($urandom_range(10, 1)), '0, 1'b1);
        end
        drain(5000);

`ifdef ARB_STATS_EN
        check("gcnt0_total", 32'(bus.gcnt0), 32'(m_ent0));
        check("gcnt1_total", 32'(bus.gcnt1), 32'(m_ent1));
`endif
        m_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
